// File: rtl/score_display_mux_pkg.sv
// -----------------------------------------------------------------------------
// score_display_mux_pkg
// Shared definitions for the score display path:
//   - segment patterns SEG_0..SEG_9 and SEG_BLANK (active-low, {g,f,e,d,c,b,a})
//   - anode one-hot-low constants for the four digit slots
//   - conversion FSM state encodings S_IDLE, S_CONV, S_COMMIT
//   - the score clamp value (99)
//   - helpers: seg_decode (BCD nibble -> segments), clamp_score
// No ports (package).
// -----------------------------------------------------------------------------
package score_display_mux_pkg;

    // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Anode enables, active-low, one slot per digit select value
    localparam logic [3:0] AN_SEL0 = 4'b1110; // player 2 ones
    localparam logic [3:0] AN_SEL1 = 4'b1101; // player 2 tens
    localparam logic [3:0] AN_SEL2 = 4'b1011; // player 1 ones
    localparam logic [3:0] AN_SEL3 = 4'b0111; // player 1 tens
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Largest score that fits in two decimal digits
    localparam logic [6:0] SCORE_CLAMP = 7'd99;

    // Number of shift/add-3 steps for a 7-bit input
    localparam logic [2:0] CONV_STEPS = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    function automatic logic [6:0] clamp_score(input logic [6:0] score);
        return (score > SCORE_CLAMP) ? SCORE_CLAMP : score;
    endfunction

endpackage

// File: rtl/score_display_mux_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: 7-bit binary in, two BCD digits out.
// A start pulse loads the input; the engine then performs one add-3/shift step
// per cycle for 7 cycles and holds the result until the next start.
// Ports:
//   clk_seg  in  1  clock
//   reset    in  1  asynchronous, active-high
//   start    in  1  load bin and begin a conversion
//   bin      in  7  binary value (caller keeps it <= 99)
//   bcd      out 8  {tens, ones}; valid once 7 steps have completed
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import score_display_mux_pkg::*;
(
    input  logic       clk_seg,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    // {tens[14:11], ones[10:7], binary[6:0]}
    logic [14:0] shreg;
    logic [14:0] adjusted;
    logic [2:0]  remaining;

    always_comb begin
        adjusted = shreg;
        if (adjusted[10:7] >= 4'd5) adjusted[10:7] = adjusted[10:7] + 4'd3;
        if (adjusted[14:11] >= 4'd5) adjusted[14:11] = adjusted[14:11] + 4'd3;
    end

    always_ff @(posedge clk_seg or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            remaining <= '0;
        end else if (start) begin
            shreg     <= {8'd0, bin};
            remaining <= CONV_STEPS;
        end else if (remaining != 3'd0) begin
            shreg     <= {adjusted[13:0], 1'b0};
            remaining <= remaining - 3'd1;
        end
    end

    assign bcd = shreg[14:7];

endmodule

// File: rtl/score_display_mux.sv
// -----------------------------------------------------------------------------
// score_display_mux
// Shows two 7-bit player scores on a 4-digit multiplexed 7-segment display.
// Left pair (an[3:2]) = player 1 tens/ones, right pair (an[1:0]) = player 2.
// Scores are clamped to 99, converted to BCD by two sequential engines run
// in lockstep, and committed to the digit registers together.
// Parameters:
//   REFRESH_DIV  clk_seg cycles per digit slot (>= 2)
//   DIV_W        prescaler width, 2**DIV_W >= REFRESH_DIV
// Ports:
//   clk_seg        in  1  display clock
//   reset          in  1  asynchronous, active-high
//   player1_score  in  7  binary score, player 1
//   player2_score  in  7  binary score, player 2
//   seg            out 7  segments, active-low {g,f,e,d,c,b,a}
//   an             out 4  anode enables, active-low one-hot
//   busy           out 1  conversion in flight (CONV or COMMIT)
// Optional feature macro: LEADING_ZERO_BLANK_EN -- when defined, a tens digit
// of 0 is blanked (anode stays active); otherwise it is shown as "0".
// -----------------------------------------------------------------------------
module score_display_mux
    import score_display_mux_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = 17
) (
    input  logic       clk_seg,
    input  logic       reset,
    input  logic [6:0] player1_score,
    input  logic [6:0] player2_score,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    // ---------------- conversion control ----------------
    state_t     state, next_state;
    logic [2:0] conv_cnt, next_conv_cnt;
    logic [6:0] p1_clamped, p2_clamped;
    logic [6:0] p1_snap, p2_snap;
    logic       start;
    logic       commit;
    logic [7:0] p1_bcd, p2_bcd;

    logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;

    assign p1_clamped = clamp_score(player1_score);
    assign p2_clamped = clamp_score(player2_score);

    always_comb begin
        next_state    = state;
        next_conv_cnt = conv_cnt;
        start         = 1'b0;
        commit        = 1'b0;
        case (state)
            S_IDLE: begin
                if ((p1_clamped != p1_snap) || (p2_clamped != p2_snap)) begin
                    start         = 1'b1;
                    next_conv_cnt = 3'd0;
                    next_state    = S_CONV;
                end
            end
            S_CONV: begin
                // The engines shift on each of these 7 cycles; the last one
                // lands together with the move to COMMIT.
                next_conv_cnt = conv_cnt + 3'd1;
                if (conv_cnt == CONV_STEPS - 3'd1) next_state = S_COMMIT;
            end
            S_COMMIT: begin
                commit     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_seg or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            conv_cnt <= '0;
        end else begin
            state    <= next_state;
            conv_cnt <= next_conv_cnt;
        end
    end

    // Snapshot is what was last started; it drives the change detector so
    // changes arriving mid-conversion are picked up on the next IDLE cycle.
    always_ff @(posedge clk_seg or posedge reset) begin
        if (reset) begin
            p1_snap <= '0;
            p2_snap <= '0;
        end else if (start) begin
            p1_snap <= p1_clamped;
            p2_snap <= p2_clamped;
        end
    end

    bin2bcd_seq u_bcd_p1 (
        .clk_seg (clk_seg),
        .reset   (reset),
        .start   (start),
        .bin     (p1_clamped),
        .bcd     (p1_bcd)
    );

    bin2bcd_seq u_bcd_p2 (
        .clk_seg (clk_seg),
        .reset   (reset),
        .start   (start),
        .bin     (p2_clamped),
        .bcd     (p2_bcd)
    );

    always_ff @(posedge clk_seg or posedge reset) begin
        if (reset) begin
            p1_tens <= '0;
            p1_ones <= '0;
            p2_tens <= '0;
            p2_ones <= '0;
        end else if (commit) begin
            p1_tens <= p1_bcd[7:4];
            p1_ones <= p1_bcd[3:0];
            p2_tens <= p2_bcd[7:4];
            p2_ones <= p2_bcd[3:0];
        end
    end

    assign busy = (state != S_IDLE);

    // ---------------- display scan ----------------
    logic [DIV_W-1:0] presc;
    logic [1:0]       sel;
    logic [3:0]       cur_digit;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;

    always_ff @(posedge clk_seg or posedge reset) begin
        if (reset) begin
            presc <= '0;
            sel   <= '0;
        end else if (presc == DIV_W'(REFRESH_DIV - 1)) begin
            presc <= '0;
            sel   <= sel + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        cur_digit = p2_ones;
        an_next   = AN_SEL0;
        case (sel)
            2'd0: begin cur_digit = p2_ones; an_next = AN_SEL0; end
            2'd1: begin cur_digit = p2_tens; an_next = AN_SEL1; end
            2'd2: begin cur_digit = p1_ones; an_next = AN_SEL2; end
            2'd3: begin cur_digit = p1_tens; an_next = AN_SEL3; end
            default: begin cur_digit = p2_ones; an_next = AN_SEL0; end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // Odd select values are the tens slots.
        if (sel[0] && (cur_digit == 4'd0)) seg_next = SEG_BLANK;
        else                               seg_next = seg_decode(cur_digit);
`else
        seg_next = seg_decode(cur_digit);
`endif
    end

    // seg and an come from the same select value in the same register stage,
    // so the pair on the pins is always consistent.
    always_ff @(posedge clk_seg or posedge reset) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_score_display_mux.sv
module tb_score_display_mux;

    localparam int RDIV = 4;

    logic       clk_seg = 1'b0;
    logic       reset   = 1'b1;
    logic [6:0] player1_score = 7'd0;
    logic [6:0] player2_score = 7'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int tests = 0;
    int fails = 0;

    // Reference segment table, active-low {g,f,e,d,c,b,a}
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    typedef struct {
        int p1;
        int p2;
        int t1;
        int o1;
        int t2;
        int o2;
    } vec_t;

    vec_t vecs [8];

    score_display_mux #(.REFRESH_DIV(RDIV), .DIV_W(3)) dut (
        .clk_seg       (clk_seg),
        .reset         (reset),
        .player1_score (player1_score),
        .player2_score (player2_score),
        .seg           (seg),
        .an            (an),
        .busy          (busy)
    );

    // ---------------- clock ----------------
    always #5 clk_seg = ~clk_seg;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] tens_seg(input int t);
`ifdef LEADING_ZERO_BLANK_EN
        if (t == 0) return 7'h7F;
`endif
        return seg_tab[t];
    endfunction

    // Compare seg against the digit the current anode selects.
    task automatic seg_now(input int t1, input int o1, input int t2, input int o2, input string tag);
        logic [6:0] e;
        case (an)
            4'b1110: e = seg_tab[o2];
            4'b1101: e = tens_seg(t2);
            4'b1011: e = seg_tab[o1];
            4'b0111: e = tens_seg(t1);
            4'b1111: e = 7'h7F;
            default: begin
                tests++;
                fails++;
                $display("FAIL %s_an: an=%b is not a legal anode pattern", tag, an);
                return;
            end
        endcase
        check({tag, "_seg"}, {28'd0, an, 1'b0, seg}, {28'd0, an, 1'b0, e});
    endtask

    // Watch one full rotation (plus slack), checking every sample.
    task automatic scan_check(input int t1, input int o1, input int t2, input int o2, input string tag);
        logic [3:0] seen;
        seen = 4'h0;
        for (int c = 0; c < 4 * RDIV + 4; c++) begin
            @(negedge clk_seg);
            seg_now(t1, o1, t2, o2, tag);
            for (int s = 0; s < 4; s++) if (an[s] == 1'b0) seen[s] = 1'b1;
        end
        check({tag, "_slots"}, {28'd0, seen}, 32'hF);
    endtask

    task automatic apply(input int p1, input int p2);
        player1_score = 7'(p1);
        player2_score = 7'(p2);
        repeat (11) @(negedge clk_seg);
    endtask

    // ---------------- stimulus ----------------
    int cnt;
    int n;
    int rp1, rp2, c1, c2;

    initial begin
        vecs[0] = '{42, 7, 4, 2, 0, 7};
        vecs[1] = '{127, 99, 9, 9, 9, 9};
        vecs[2] = '{99, 100, 9, 9, 9, 9};
        vecs[3] = '{0, 5, 0, 0, 0, 5};
        vecs[4] = '{60, 38, 6, 0, 3, 8};
        vecs[5] = '{9, 90, 0, 9, 9, 0};
        vecs[6] = '{100, 10, 9, 9, 1, 0};
        vecs[7] = '{15, 64, 1, 5, 6, 4};

        // 1. reset state and idle scan
        repeat (3) @(negedge clk_seg);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        scan_check(0, 0, 0, 0, "idle00");
        n = 0;
        while (an != 4'b1101 && n < 20) begin @(negedge clk_seg); n++; end
        check("slot_found", {31'd0, an == 4'b1101}, 32'd1);
        cnt = 0;
        while (an == 4'b1101 && cnt < 20) begin @(negedge clk_seg); cnt++; end
        check("slot_len", cnt, RDIV);

        // 2. 42/7 from IDLE: busy for 8 cycles, then display
        player1_score = 7'd42;
        player2_score = 7'd7;
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_seg);
            if (busy) cnt++;
            if (k == 1) check("busy_rise", {31'd0, busy}, 32'd1);
            if (k == 8) check("busy_last", {31'd0, busy}, 32'd1);
            if (k == 9) check("busy_fall", {31'd0, busy}, 32'd0);
        end
        check("busy_len", cnt, 8);
        scan_check(4, 2, 0, 7, "s42_07");

        // 3. table of vectors incl. clamp and blanking cases
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].p1, vecs[i].p2);
            scan_check(vecs[i].t1, vecs[i].o1, vecs[i].t2, vecs[i].o2, $sformatf("vec%0d", i));
        end

        // 4. change p1 13->56 during the 3rd CONV cycle (p2 stays 64)
        player1_score = 7'd13;
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_seg);
            if (busy) cnt++;
            if (k == 9) check("reconv_gap", {31'd0, busy}, 32'd0);
            if (k == 10) check("reconv_start", {31'd0, busy}, 32'd1);
            if (k >= 10 && k <= 18) seg_now(1, 3, 6, 4, "first_commit13");
            if (k == 3) player1_score = 7'd56;
        end
        check("reconv_busy_len", cnt, 16);
        scan_check(5, 6, 6, 4, "second_commit56");

        // 5. reset during CONV, then reconversion after release
        player1_score = 7'd77;
        player2_score = 7'd7;
        repeat (3) @(negedge clk_seg);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_seg", {25'd0, seg}, 32'h7F);
        check("async_rst_an", {28'd0, an}, 32'hF);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk_seg);
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_seg);
            if (k == 1) check("post_rst_busy", {31'd0, busy}, 32'd1);
            seg_now(0, 0, 0, 0, "post_rst00");
        end
        repeat (3) @(negedge clk_seg);
        scan_check(7, 7, 0, 7, "post_rst77");

        // 6. randomized scores against arithmetic model
        for (int i = 0; i < 25; i++) begin
            rp1 = $urandom_range(0, 127);
            rp2 = $urandom_range(0, 127);
            c1 = (rp1 > 99) ? 99 : rp1;
            c2 = (rp2 > 99) ? 99 : rp2;
            apply(rp1, rp2);
            scan_check(c1 / 10, c1 % 10, c2 / 10, c2 % 10, $sformatf("rnd%0d_%0d_%0d", i, rp1, rp2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
